// File: rtl/instr_pkg.sv
// Shared constants, field layout and FSM type for the instruction
// issue stage and the decoder it feeds.
package instr_pkg;

    localparam int OPCODE_W = 4;
    localparam int PARAM_W  = 6;
    localparam int INSTR_W  = 16;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int P1_MSB = 11;
    localparam int P1_LSB = 6;
    localparam int P2_MSB = 5;
    localparam int P2_LSB = 0;

    localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

    typedef enum logic {
        RUN,
        HALTED
    } issue_state_t;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OPCODE_W-1:0] op,
        input logic [PARAM_W-1:0]  p1,
        input logic [PARAM_W-1:0]  p2
    );
        logic [INSTR_W-1:0] w;
        w                = '0;
        w[OP_MSB:OP_LSB] = op;
        w[P1_MSB:P1_LSB] = p1;
        w[P2_MSB:P2_LSB] = p2;
        return w;
    endfunction

    function automatic logic [OPCODE_W-1:0] opcode_of(
        input logic [INSTR_W-1:0] w
    );
        return w[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular-buffer FIFO with explicit occupancy counter.
// Pushes while full and pops while empty are ignored.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Issue stage: buffers sequencer instructions and strobes them
// into the decoder one per cycle, stopping after a HALT opcode.
module instr_issue
    import instr_pkg::*;
#(
    parameter int                   DEPTH   = 4,
    parameter logic [OPCODE_W-1:0]  HALT_OP = instr_pkg::HALT_OP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [OPCODE_W-1:0]      in_opcode,
    input  logic [PARAM_W-1:0]       in_param1,
    input  logic [PARAM_W-1:0]       in_param2,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     resume,
    output logic [INSTR_W-1:0]       instr,
    output logic                     en,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    issue_state_t       state;
    issue_state_t       next_state;
    logic [INSTR_W-1:0] head;
    logic [INSTR_W-1:0] packed_in;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign packed_in = pack_instr(in_opcode, in_param1, in_param2);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (packed_in),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Next state, pop decision and halted flag.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        halted     = 1'b0;
        case (state)
            RUN: begin
                pop = !empty && !stall;
                if (pop && opcode_of(head) == HALT_OP) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Output registers; instr holds its last issued word between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= '0;
            en    <= 1'b0;
        end else begin
            en <= pop;
            if (pop) begin
                instr <= head;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios followed
// by random traffic, compared against a queue-based reference model.
module tb_instr_issue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_opcode = '0;
    logic [5:0]  in_param1 = '0;
    logic [5:0]  in_param2 = '0;
    logic        stall = 1'b0;
    logic        resume = 1'b0;
    logic        in_ready;
    logic [15:0] instr;
    logic        en;
    logic        halted;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    logic [15:0] mq[$];
    logic        m_en = 1'b0;
    logic [15:0] m_instr = '0;
    logic        m_halt = 1'b0;

    instr_issue #(
        .DEPTH   (DEPTH),
        .HALT_OP (4'hF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_opcode (in_opcode),
        .in_param1 (in_param1),
        .in_param2 (in_param2),
        .in_ready  (in_ready),
        .stall     (stall),
        .resume    (resume),
        .instr     (instr),
        .en        (en),
        .halted    (halted),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] w,
                        input logic st, input logic rs,
                        input logic rst);
        logic rdy;
        logic was_halt;
        in_valid = v;
        {in_opcode, in_param1, in_param2} = w;
        stall  = st;
        resume = rs;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_en    = 1'b0;
            m_instr = '0;
            m_halt  = 1'b0;
        end else begin
            rdy      = (mq.size() < DEPTH);
            was_halt = m_halt;
            m_en     = 1'b0;
            if (!m_halt && mq.size() > 0 && !st) begin
                m_instr = mq.pop_front();
                m_en    = 1'b1;
                if (m_instr[15:12] == 4'hF) m_halt = 1'b1;
            end
            if (was_halt && rs) m_halt = 1'b0;
            if (v && rdy) mq.push_back(w);
        end
        #1;
        chk("en", 32'(en), 32'(m_en));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("count", 32'(count), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] w;

        // reset values
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);

        // single instruction, two-cycle latency
        step(1'b1, 16'h316A, 1'b0, 1'b0, 1'b0);
        chk("lat_no_en", 32'(en), 32'h0);
        idle(1);
        chk("lat_instr", 32'(instr), 32'h316A);
        chk("lat_en", 32'(en), 32'h1);
        idle(2);

        // fill under stall, fifth push refused, then drain
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h4000 + 16'(i), 1'b1, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h4004, 1'b0, 1'b0, 1'b0);
        idle(6);

        // halt then resume
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2ABC, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_instr", 32'(instr), 32'hF000);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("resume_wait", 32'(en), 32'h0);
        idle(1);
        chk("resume_instr", 32'(instr), 32'h2ABC);
        idle(2);

        // streaming with pointer wrap
        for (int i = 0; i < 10; i++)
            step(1'b1, 16'h5000 + 16'(i * 3), 1'b0, 1'b0, 1'b0);
        idle(3);

        // reset with count=3 and en=1
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'h6100 + 16'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h6199, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_en", 32'(en), 32'h0);

        // resume while running and empty
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            w = 16'($urandom);
            step(1'($urandom_range(0, 2) != 0), w,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue stage that drives the 16-bit instruction decoder: accepts opcode/parameter triples from the sequencer over a valid/ready handshake, buffers them in a small FIFO, packs each into the `{opcode, param1, param2}` word and presents it with a one-cycle `en` strobe. A HALT opcode stops issue until software pulses `resume`. Sits directly upstream of the decoder; its `instr`/`en` outputs connect to the decoder's `instr`/`en` inputs.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `HALT_OP`, 4'hF, opcode that halts issue after it is sent
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  sequencer offers an instruction
- `in_opcode`  in  4  opcode, becomes instr[15:12]
- `in_param1`  in  6  becomes instr[11:6]
- `in_param2`  in  6  becomes instr[5:0]
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid && in_ready`
- `stall`  in  1  downstream hold; no issue while high
- `resume`  in  1  single-cycle pulse leaving HALTED
- `instr`  out  16  packed instruction, registered
- `en`  out  1  one-cycle strobe: `instr` valid this cycle
- `halted`  out  1  high in HALTED state
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Packing: `instr = {opcode[3:0], param1[5:0], param2[5:0]}`; no field truncation or sign extension.
- FIFO: circular buffer, read/write pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH; separate occupancy counter.
- `in_ready = (count < DEPTH)`; combinational from registered count only (no pop-through when full).
- Push on edge with `in_valid && in_ready`; writing while not ready is ignored, data dropped by design (sequencer must obey ready).
- FSM states: RUN, HALTED.
  - RUN: at edge with `count>0 && !stall` → pop head, `instr<=packed head`, `en<=1`. Otherwise `en<=0`, `instr` holds.
  - RUN, popped opcode == HALT_OP → HALTED at same edge (HALT word itself is issued).
  - HALTED: no pops, `en<=0`, `halted=1`; pushes still accepted until full. `resume` → RUN at next edge; first pop no earlier than the edge after that.
  - `resume` in RUN: ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pop from empty never occurs; push to full never occurs.

## Timing
- Reset values: state RUN, `count=0`, pointers 0, `instr=16'h0000`, `en=0`, `halted=0`, `in_ready=1`.
- Reset mid-operation: FIFO contents discarded, in-flight `en` cleared on reset edge; no instruction issued in the reset cycle.
- Latency: push at edge k → pop at edge k+1 (earliest) → `en=1` during cycle k+1..k+2. Two-cycle min latency, no bypass.
- Throughput: one instruction per cycle with stall low and FIFO non-empty.
- `stall` sampled at edge; stall high at edge k → no `en` in following cycle; `instr` retains last issued value.
- `en` never high for two cycles with the same FIFO entry.

## Structure
- Shared package `instr_pkg`: `OPCODE_W=4`, `PARAM_W=6`, `INSTR_W=16`, field bit positions, `HALT_OP`, FSM enum `issue_state_t {RUN, HALTED}`; decoder-side field extraction uses the same constants.
- Sub-module `instr_fifo` (parameterised width/depth, push/pop/count/full/empty); top holds FSM and output registers.

## Test plan
- Reset then push `{4'h3, 6'h05, 6'h2A}` at edge 1 → `en=1`, `instr=16'h316A` during cycle after edge 2; `count` returns to 0.
- Stall high, push 5 items with DEPTH=4 → 4 accepted, `in_ready=0`, `count=4`, 5th held by sequencer; release stall → 4 consecutive `en` cycles in push order, then 5th.
- Push `{4'h1,…}`, `{4'hF,6'h0,6'h0}`, `{4'h2,…}` → instrs 0x1xxx, 0xF000 issued, `halted=1`, 0x2xxx held; `resume` pulse → 0x2xxx issued two edges later.
- Continuous push/pop 10 items at full rate → pointer wrap, order preserved, `count` stays 1.
- Reset asserted with `count=3` and `en=1` → next cycle `en=0`, `count=0`, `instr=0`, `in_ready=1`.
- `resume` pulsed in RUN with FIFO empty → no `en`, state stays RUN.
